// File: rtl/abus_pkg.sv
// abus_pkg: encodings shared by every abus slave (FSM states and transfer direction).
package abus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } abus_state_e;

    typedef enum logic {
        ABUS_READ  = 1'b0,
        ABUS_WRITE = 1'b1
    } abus_dir_e;

endpackage

// File: rtl/abus_slave_decode.sv
// abus_slave_decode: combinational address window check and register index for abus slaves.
module abus_slave_decode
    import abus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int NB_REGS    = 8,
    parameter int IDX_WIDTH  = 3
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_hit,
    output logic [IDX_WIDTH-1:0]  o_index
);

    // One extra bit so a window ending exactly at the top of the address space does not wrap.
    localparam logic [ADDR_WIDTH:0]   LP_LOW  = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LP_HIGH = (ADDR_WIDTH+1)'(BASE_ADDR + NB_REGS);
    localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

    // Range check and offset from the window base.
    always_comb begin
        if (({1'b0, i_addr} >= LP_LOW) && ({1'b0, i_addr} < LP_HIGH)) begin
            o_hit   = 1'b1;
            o_index = IDX_WIDTH'(i_addr - LP_BASE);
        end else begin
            o_hit   = 1'b0;
            o_index = {IDX_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/abus_slave.sv
// abus_slave: register-file slave on the arbitrated abus with registered, single-strobe responses.
// Define ABUS_SLAVE_WAIT_EN to insert WAIT_STATES extra cycles; otherwise bus_sready follows accept by one cycle.
module abus_slave
    import abus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int BASE_ADDR   = 0,
    parameter int NB_REGS     = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                                bus_clk,
    input  logic                                bus_rstb,
    input  logic                                bus_svalid,
    input  logic                                bus_swrite,
    input  logic [ADDR_WIDTH-1:0]               bus_saddress,
    input  logic [DATA_WIDTH-1:0]               bus_swdata,
    output logic                                bus_sready,
    output logic [DATA_WIDTH-1:0]               bus_srdata,
    output logic [$clog2(DATA_WIDTH+1)-1:0]     bus_sstrb,
    output logic [$clog2(DATA_WIDTH+1)-1:0]     bus_skeep,
    output logic [NB_REGS*DATA_WIDTH-1:0]       regs_q
);

    localparam int            CW        = $clog2(DATA_WIDTH + 1);
    localparam int            IDX_WIDTH = (NB_REGS > 1) ? $clog2(NB_REGS) : 1;
    localparam logic [CW-1:0] LP_FULL   = CW'(DATA_WIDTH);

    abus_state_e                        r_state;
    logic                               r_ready;
    logic [DATA_WIDTH-1:0]              r_rdata;
    logic [CW-1:0]                      r_strb;
    logic [CW-1:0]                      r_keep;
    logic [NB_REGS-1:0][DATA_WIDTH-1:0] r_regs;

    logic                               w_hit;
    logic [IDX_WIDTH-1:0]               w_index;
    logic                               w_enter_resp;
    logic                               w_rsp_write;
    logic [IDX_WIDTH-1:0]               w_rsp_idx;
    logic [DATA_WIDTH-1:0]              w_rsp_wdata;

`ifdef ABUS_SLAVE_WAIT_EN
    localparam bit         LP_NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [3:0]            r_cnt;
    logic                  r_cap_write;
    logic [IDX_WIDTH-1:0]  r_cap_idx;
    logic [DATA_WIDTH-1:0] r_cap_wdata;
`endif

    abus_slave_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .NB_REGS    (NB_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_decode (
        .i_addr  (bus_saddress),
        .o_hit   (w_hit),
        .o_index (w_index)
    );

    // Decide whether this edge enters RESP and which request (live or captured) it serves.
    always_comb begin
        w_enter_resp = 1'b0;
        w_rsp_write  = (bus_swrite == ABUS_WRITE);
        w_rsp_idx    = w_index;
        w_rsp_wdata  = bus_swdata;
        case (r_state)
            ST_IDLE: begin
`ifdef ABUS_SLAVE_WAIT_EN
                w_enter_resp = bus_svalid && w_hit && LP_NO_WAIT;
`else
                w_enter_resp = bus_svalid && w_hit;
`endif
            end
`ifdef ABUS_SLAVE_WAIT_EN
            ST_WAIT: begin
                // A dropped request in the last wait cycle is an abort, not a response.
                w_enter_resp = bus_svalid && (r_cnt == 4'd0);
                w_rsp_write  = r_cap_write;
                w_rsp_idx    = r_cap_idx;
                w_rsp_wdata  = r_cap_wdata;
            end
`endif
            default: begin
                w_enter_resp = 1'b0;
            end
        endcase
    end

    // Transaction FSM, register file and registered response outputs.
    always_ff @(posedge bus_clk or negedge bus_rstb) begin
        if (!bus_rstb) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_rdata <= {DATA_WIDTH{1'b0}};
            r_strb  <= {CW{1'b0}};
            r_keep  <= {CW{1'b0}};
            r_regs  <= {(NB_REGS*DATA_WIDTH){1'b0}};
`ifdef ABUS_SLAVE_WAIT_EN
            r_cnt       <= 4'd0;
            r_cap_write <= 1'b0;
            r_cap_idx   <= {IDX_WIDTH{1'b0}};
            r_cap_wdata <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus_svalid && w_hit) begin
`ifdef ABUS_SLAVE_WAIT_EN
                        r_cap_write <= (bus_swrite == ABUS_WRITE);
                        r_cap_idx   <= w_index;
                        r_cap_wdata <= bus_swdata;
                        if (LP_NO_WAIT) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= LP_WAIT_LOAD;
                        end
`else
                        r_state <= ST_RESP;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
`ifdef ABUS_SLAVE_WAIT_EN
                ST_WAIT: begin
                    if (!bus_svalid) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`endif
                // Request still held by the master here is deliberately ignored.
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_enter_resp) begin
                r_ready <= 1'b1;
                if (w_rsp_write) begin
                    r_regs[w_rsp_idx] <= w_rsp_wdata;
                    r_rdata           <= {DATA_WIDTH{1'b0}};
                    r_strb            <= {CW{1'b0}};
                    r_keep            <= LP_FULL;
                end else begin
                    r_rdata <= r_regs[w_rsp_idx];
                    r_strb  <= LP_FULL;
                    r_keep  <= {CW{1'b0}};
                end
            end else begin
                r_ready <= 1'b0;
                r_rdata <= {DATA_WIDTH{1'b0}};
                r_strb  <= {CW{1'b0}};
                r_keep  <= {CW{1'b0}};
            end
        end
    end

    assign bus_sready = r_ready;
    assign bus_srdata = r_rdata;
    assign bus_sstrb  = r_strb;
    assign bus_skeep  = r_keep;
    assign regs_q     = r_regs;

endmodule

// File: doc/abus_slave.md
ABUS_SLAVE -- requirements
Module: abus_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, bus data width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, word address of register 0.
REQ-004 SHALL have parameter NB_REGS, default 8, number of registers (range 1..256).
REQ-005 SHALL have parameter WAIT_STATES, default 1, added response cycles (range 0..15).
REQ-006 SHALL have the port bus_clk  input  1  single clock; all state on its rising edge.
REQ-007 SHALL have the port bus_rstb  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have the port bus_svalid  input  1  request valid from the arbiter.
REQ-009 SHALL have the port bus_swrite  input  1  1 = write, 0 = read.
REQ-010 SHALL have the port bus_saddress  input  ADDR_WIDTH  word address.
REQ-011 SHALL have the port bus_swdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have the port bus_sready  output  1  one-cycle response strobe.
REQ-013 SHALL have the port bus_srdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have the port bus_sstrb  output  $clog2(DATA_WIDTH+1)  count of valid read-data bits.
REQ-015 SHALL have the port bus_skeep  output  $clog2(DATA_WIDTH+1)  count of bits written.
REQ-016 SHALL have the port regs_q  output  NB_REGS*DATA_WIDTH  register contents, register 0 in the LSBs.

Function
REQ-017 SHALL decode a hit when BASE_ADDR <= bus_saddress < BASE_ADDR+NB_REGS; index = bus_saddress-BASE_ADDR.
REQ-018 SHALL implement the FSM IDLE, WAIT and RESP, with all outputs registered.
REQ-019 SHALL move from IDLE to WAIT, loading the counter with WAIT_STATES-1, when it samples bus_svalid with a hit and WAIT_STATES>0.
REQ-020 SHALL move from IDLE straight to RESP on the same condition when WAIT_STATES=0.
REQ-021 SHALL stay in IDLE with all outputs idle on a miss; no response, since another slave owns the address.
REQ-022 SHALL decrement the counter in WAIT and go to RESP when it reaches 0.
REQ-023 SHALL drive bus_sready=1 for exactly the RESP cycle, first seen WAIT_STATES+1 cycles after the accepting edge, then return to IDLE.
REQ-024 SHALL require the master to hold bus_svalid/swrite/saddress/swdata stable from accept until bus_sready is sampled; the slave uses the captured copy.
REQ-025 SHALL, for a read, output register[index] on bus_srdata with bus_sstrb=DATA_WIDTH and bus_skeep=0 during RESP.
REQ-026 SHALL, for a write, update register[index] on the edge entering RESP, with bus_skeep=DATA_WIDTH, bus_sstrb=0 and bus_srdata=0 during RESP.
REQ-027 SHALL, when bus_svalid falls in WAIT, abort to IDLE with no write and no bus_sready.
REQ-028 SHALL ignore bus_svalid sampled at the edge leaving RESP; the earliest next accept is the following edge, so the minimum period is WAIT_STATES+2 cycles.
REQ-029 SHALL hold bus_srdata, bus_sstrb and bus_skeep at 0 outside RESP.

Reset
REQ-030 SHALL, on bus_rstb low, immediately and asynchronously set state=IDLE, counter=0, bus_sready=0, bus_srdata=0, bus_sstrb=0, bus_skeep=0 and all registers (regs_q)=0.
REQ-031 SHALL, on reset mid-transaction, drop the pending access with no write and no response.

Configuration
REQ-032 SHALL, with ABUS_SLAVE_WAIT_EN defined, honour WAIT_STATES and include the WAIT state and counter.
REQ-033 SHALL, without ABUS_SLAVE_WAIT_EN, omit the WAIT state and counter, ignore WAIT_STATES, and go IDLE to RESP, so bus_sready comes 1 cycle after accept.

Structure
REQ-034 SHALL take the FSM state encodings (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) from the shared package abus_pkg, with the read/write encodings of bus_swrite.
REQ-035 SHALL put the address range check and index computation in the sub-module abus_slave_decode (combinational hit and index), shared with future abus slaves.

Verification
REQ-036 SHALL cover: WAIT_STATES=1, write 0x1234 to BASE_ADDR+3 -> bus_sready high 2 cycles after accept, skeep=16, regs_q[63:48]=0x1234.
REQ-037 SHALL cover: read BASE_ADDR+3 after that write -> srdata=0x1234, sstrb=16, skeep=0 in the bus_sready cycle, and 0 in all other cycles.
REQ-038 SHALL cover: access to BASE_ADDR+NB_REGS (miss) held 10 cycles -> bus_sready stays 0 and regs_q is unchanged.
REQ-039 SHALL cover: WAIT_STATES=3, write to reg 1 with bus_svalid dropped after 2 cycles -> no bus_sready and reg 1 still 0.
REQ-040 SHALL cover: bus_rstb pulsed low during WAIT of a write -> outputs 0 at once, registers 0, no response after release.
REQ-041 SHALL cover: build without ABUS_SLAVE_WAIT_EN and WAIT_STATES=5, back-to-back reads -> bus_sready 1 cycle after each accept and a 2-cycle minimum period.
